// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised LED counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Divides clk by PRESCALE into a one-cycle tick; pauses (not restarts) while en is low.
module clk_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, clr};
    assign tick      = en;
  end else begin : g_div
    localparam int              PW   = clog2_min1(PRESCALE);
    localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
      pre_d = pre_q;
      if (clr)      pre_d = '0;
      else if (en)  pre_d = (pre_q == PMAX) ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
    end

    assign tick = en & (pre_q == PMAX);
  end

endmodule

// File: rtl/param_led_counter.sv
// Up/down LED counter with prescaler, wrap/saturate mode, parallel load and terminal-count pulse.
module param_led_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               PRESCALE  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  clk_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign at_term = (dir == DIR_DOWN) ? (count_q == '0) : (count_q == '1);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (tick) begin
      if (at_term) begin
        tc_d = 1'b1;
        if (sat != MODE_SAT) count_d = (dir == DIR_DOWN) ? '1 : '0;
      end else begin
        count_d = (dir == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: doc/param_led_counter.md
Name: param_led_counter

Overview:
- Parametrised successor to the fixed 4-bit free-running LED counter top.
- Synchronous up/down counter with configurable width, clock prescaler, wrap or saturate mode, parallel load, count enable and a terminal-count pulse.
- Instantiated directly under a board-level top that drives LEDs. Also used standalone in post-route SDF simulation benches.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- PRESCALE, 1, clk edges per count step (1..2^16). With 1, the counter steps every clk edge.
- RESET_VAL, 0, value loaded into count on reset (WIDTH bits).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; gates both the prescaler and the counter.
- dir  input  1  0 = count up, 1 = count down.
- sat  input  1  0 = wrap at terminal value, 1 = saturate (hold) at terminal value.
- load  input  1  parallel-load strobe.
- load_val  input  WIDTH  value captured when load is high.
- count  output  WIDTH  registered counter value; drives the LEDs.
- tc  output  1  registered terminal-count pulse.

Behaviour:
- All state is registered on the rising edge of clk. No combinational path from inputs to outputs.
- Reset (rst=1 at an edge):
  - count <= RESET_VAL, tc <= 0, prescaler <= 0.
  - Applies even in the middle of a prescale period or a load.
- Priority at each edge: rst > load > (en & tick) > hold.
- Prescaler (internal, width clog2(PRESCALE), omitted when PRESCALE=1):
  - tick = en & (pre == PRESCALE-1). With PRESCALE=1, tick = en.
  - When en=1: pre increments, wrapping to 0 after PRESCALE-1.
  - When en=0: pre holds its value; the next period resumes where it stopped, not from 0.
- Load (load=1, rst=0):
  - count <= load_val, pre <= 0, tc <= 0.
  - en is ignored on that edge.
- Terminal value: all-ones when dir=0, zero when dir=1. dir is sampled on the same edge as tick.
- Step (tick=1, load=0, rst=0):
  - Not at terminal: count <= count+1 (up) or count-1 (down); tc <= 0.
  - At terminal with sat=0: count wraps to 0 (up) or to all-ones (down); tc <= 1.
  - At terminal with sat=1: count holds; tc <= 1 on every tick while held.
- tc is high for exactly one clk cycle per qualifying tick. It is 0 on every edge without a step.
- Latency: count changes on the same edge at which tick is true. Observable one cycle after the enabling input condition.
- Changing dir or sat between ticks takes effect on the next tick. No pipeline flush or extra latency.
- Arithmetic is modulo 2^WIDTH. No carry out beyond tc.

Decomposition:
- Shared package counter_pkg:
  - localparams DIR_UP=1'b0, DIR_DOWN=1'b1, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - Function clog2_min1 for the prescaler width.
- Sub-module clk_prescaler (parameter PRESCALE; ports clk, rst, en, clr, tick) holds the prescale counter.
  - clr is driven by load.
- The counter/tc logic stays in param_led_counter.

Test Plan:
- Regression of the previous block: WIDTH=4, PRESCALE=1, en=1, dir=0, sat=0, 63 rising edges after reset. After edge i, count === i%16, and tc=1 exactly after edges 16, 32 and 48.
- Prescaler: WIDTH=4, PRESCALE=4, en=1. Count steps 0→1 on the 4th edge and 1→2 on the 8th. Deassert en for 3 edges mid-period, then resume: the step is delayed by exactly 3 edges.
- Down wrap: WIDTH=4, dir=1 from reset. First tick: count=15, tc=1. Next tick: count=14, tc=0.
- Saturate: WIDTH=4, load 14, sat=1, dir=0. Ticks give 15 (tc=0), 15 (tc=1), 15 (tc=1). Switch dir=1: next tick gives 14, tc=0.
- Load priority: PRESCALE=4, load=1 with load_val=9 on the same edge as a tick. count=9, tc=0, and the next step occurs 4 edges later.
- Reset mid-operation: RESET_VAL=5, rst=1 while load=1 and a tick are pending. Result: count=5, tc=0, prescaler restarts, so the first step comes PRESCALE edges after rst falls.
